pipelined_prefix_adder: RTL and testbench
=========================================

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal range 2..64, any value (not restricted to powers of two).
REQ-002 SHALL derive LEVEL = $clog2(WIDTH), the number of Kogge-Stone prefix levels; not overridable.
REQ-003 i_Clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_Rst  input  1  reset, synchronous, active-high.
REQ-005 i_Valid  input  1  upstream operand valid.
REQ-006 o_Ready  output  1  block accepts operands this cycle.
REQ-007 i_A, i_B  input  WIDTH  operands.
REQ-008 i_Cin  input  1  carry-in.
REQ-009 o_Valid  output  1  result valid.
REQ-010 i_Ready  input  1  downstream accepts result.
REQ-011 o_Sum  output  WIDTH  sum.
REQ-012 o_Cout  output  1  carry-out of bit WIDTH-1.
REQ-013 o_Overflow  output  1  two's-complement signed overflow.

Function
REQ-014 Stage 0 SHALL register bitwise P = A^B and G = A&B, with bit 0 G = A0&B0 | (A0^B0)&Cin; the raw P vector SHALL travel alongside for sum formation.
REQ-015 Stage i (1..LEVEL) SHALL register one prefix level: for bit j >= 2^(i-1), G = Gj | Pj&G(j-2^(i-1)) and P = Pj&P(j-2^(i-1)); for j < 2^(i-1), pass through unchanged.
REQ-016 o_Sum SHALL be formed combinationally from final-stage registers: Sum0 = P0^Cin_carried, Sumj = Pj^G(j-1); o_Cout = G(WIDTH-1); o_Overflow = carry into MSB XOR o_Cout.
REQ-017 Latency SHALL be LEVEL+1 cycles from accepted input (i_Valid & o_Ready) to o_Valid (5 for WIDTH=16).
REQ-018 Each stage SHALL hold a valid bit; stage k advances when its successor is empty or advancing; final stage advances on i_Ready or when empty.
REQ-019 o_Ready SHALL equal the stage-0 advance condition, so bubbles are absorbed and throughput is one result per cycle while i_Ready=1.
REQ-020 When o_Valid=1 and i_Ready=0, o_Sum/o_Cout/o_Overflow/o_Valid SHALL hold stable; no result is dropped or duplicated, order preserved.
REQ-021 Stage data registers SHALL load only on accepted transfer; invalid stages need not clear data.

Reset
REQ-022 With i_Rst=1 at a rising edge, all stage valid bits SHALL clear; o_Valid=0 in the following cycle.
REQ-023 Reset outputs: o_Valid=0, o_Ready=1 after reset, o_Sum/o_Cout/o_Overflow=0 (data registers cleared).
REQ-024 Reset mid-operation SHALL discard all in-flight operands; none appear after reset deasserts.

Configuration
REQ-025 Macro PREFIX_ADDER_SUB_EN: when defined, adds port i_Sub (input, 1, per-operand, captured with operands); i_Sub=1 computes A + ~B + 1 (i_Cin ignored), o_Cout=1 means no borrow.
REQ-026 Without PREFIX_ADDER_SUB_EN, i_Sub SHALL not exist and the block SHALL only add.

Verification
REQ-027 WIDTH=16, A=0xFFFF, B=0x0001, Cin=0, i_Ready=1 -> 5 cycles later o_Sum=0x0000, o_Cout=1, o_Overflow=0.
REQ-028 WIDTH=16, A=0x7FFF, B=0x0001, Cin=0 -> o_Sum=0x8000, o_Cout=0, o_Overflow=1.
REQ-029 8 back-to-back operands (A=n, B=n, n=1..8), i_Ready=0 for 3 cycles once first result appears -> o_Ready drops when pipeline full, outputs held, then 2,4,...,16 delivered in order with no loss.
REQ-030 i_Rst=1 for 1 cycle with 3 operands in flight -> o_Valid=0 next cycle and stays 0 until new input accepted.
REQ-031 PREFIX_ADDER_SUB_EN defined, WIDTH=16, A=0x0005, B=0x0007, i_Sub=1 -> o_Sum=0xFFFE, o_Cout=0.
REQ-032 WIDTH=12 (non-power-of-two, LEVEL=4), A=0x000, B=0x000, Cin=1 -> o_Sum=0x001, o_Cout=0, latency 5; random 10k-vector sweep matches A+B+Cin.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone prefix adder with valid/ready flow control.
// One stage forms bitwise P/G, then one register stage per prefix level;
// the sum is formed combinationally from the final stage registers.
//
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_Valid, o_Ready    upstream handshake (operands i_A, i_B, i_Cin)
//   o_Valid, i_Ready    downstream handshake (o_Sum, o_Cout, o_Overflow)
//   i_Sub               only with PREFIX_ADDER_SUB_EN: computes A + ~B + 1
//
// Build option: define PREFIX_ADDER_SUB_EN to add the i_Sub port.
module pipelined_prefix_adder #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
`ifdef PREFIX_ADDER_SUB_EN
    input  logic             i_Sub,
`endif
    input  logic             i_Cin,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout,
    output logic             o_Overflow
);

    localparam int LEVEL = $clog2(WIDTH);

    logic [LEVEL:0]   vld_q;
    logic [LEVEL:0]   adv;
    logic [WIDTH-1:0] g_q   [0:LEVEL];
    logic [WIDTH-1:0] p_q   [0:LEVEL];
    logic [WIDTH-1:0] raw_q [0:LEVEL];
    logic             cin_q [0:LEVEL];

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;

    // A stage may advance if it, or any stage after it, is empty, or if
    // the output is being consumed; this lets bubbles be squeezed out.
    for (genvar k = 0; k <= LEVEL; k++) begin : g_adv
        assign adv[k] = i_Ready | ~(&vld_q[LEVEL:k]);
    end

    assign o_Ready = adv[0];

`ifdef PREFIX_ADDER_SUB_EN
    assign b_eff   = i_Sub ? ~i_B : i_B;
    assign cin_eff = i_Sub ? 1'b1 : i_Cin;
`else
    assign b_eff   = i_B;
    assign cin_eff = i_Cin;
`endif

    // Carry-in is folded into the bit-0 generate so the prefix tree
    // needs no separate carry input.
    always_comb begin
        p0    = i_A ^ b_eff;
        g0    = i_A & b_eff;
        g0[0] = (i_A[0] & b_eff[0]) | (p0[0] & cin_eff);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            vld_q[0] <= 1'b0;
            g_q[0]   <= '0;
            p_q[0]   <= '0;
            raw_q[0] <= '0;
            cin_q[0] <= 1'b0;
        end else if (adv[0]) begin
            vld_q[0] <= i_Valid;
            if (i_Valid) begin
                g_q[0]   <= g0;
                p_q[0]   <= p0;
                raw_q[0] <= p0;
                cin_q[0] <= cin_eff;
            end
        end
    end

    for (genvar k = 1; k <= LEVEL; k++) begin : g_lvl
        localparam int D = 1 << (k - 1);
        // Bits below the span distance pass through unchanged.
        localparam logic [WIDTH-1:0] LOW = ~({WIDTH{1'b1}} << D);

        logic [WIDTH-1:0] g_nx;
        logic [WIDTH-1:0] p_nx;

        assign g_nx = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << D));
        assign p_nx = p_q[k-1] & ((p_q[k-1] << D) | LOW);

        always_ff @(posedge i_Clk) begin
            if (i_Rst) begin
                vld_q[k] <= 1'b0;
                g_q[k]   <= '0;
                p_q[k]   <= '0;
                raw_q[k] <= '0;
                cin_q[k] <= 1'b0;
            end else if (adv[k]) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    g_q[k]   <= g_nx;
                    p_q[k]   <= p_nx;
                    raw_q[k] <= raw_q[k-1];
                    cin_q[k] <= cin_q[k-1];
                end
            end
        end
    end

    // Final-stage G holds the carry out of each bit position.
    logic [WIDTH-1:0] gl;
    assign gl = g_q[LEVEL];

    assign o_Valid    = vld_q[LEVEL];
    assign o_Sum      = raw_q[LEVEL] ^ {gl[WIDTH-2:0], cin_q[LEVEL]};
    assign o_Cout     = gl[WIDTH-1];
    assign o_Overflow = gl[WIDTH-2] ^ gl[WIDTH-1];

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder (WIDTH=16 and WIDTH=12).
// Scoreboard queues hold expected results; monitors compare on transfer.
module tb_pipelined_prefix_adder;

    logic clk;
    logic rst;

    logic        v16, rdy16, cin16;
    logic [15:0] a16, b16;
    logic        o_ready16, o_valid16, o_cout16, o_ovf16;
    logic [15:0] o_sum16;
`ifdef PREFIX_ADDER_SUB_EN
    logic        sub16;
    logic        sub12;
`endif

    logic        v12, rdy12, cin12;
    logic [11:0] a12, b12;
    logic        o_ready12, o_valid12, o_cout12, o_ovf12;
    logic [11:0] o_sum12;

    logic [17:0] sb16 [$];
    logic [12:0] sb12 [$];

    int n_total = 0;
    int n_fail  = 0;

    pipelined_prefix_adder #(.WIDTH(16)) dut16 (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Valid    (v16),
        .o_Ready    (o_ready16),
        .i_A        (a16),
        .i_B        (b16),
`ifdef PREFIX_ADDER_SUB_EN
        .i_Sub      (sub16),
`endif
        .i_Cin      (cin16),
        .o_Valid    (o_valid16),
        .i_Ready    (rdy16),
        .o_Sum      (o_sum16),
        .o_Cout     (o_cout16),
        .o_Overflow (o_ovf16)
    );

    pipelined_prefix_adder #(.WIDTH(12)) dut12 (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Valid    (v12),
        .o_Ready    (o_ready12),
        .i_A        (a12),
        .i_B        (b12),
`ifdef PREFIX_ADDER_SUB_EN
        .i_Sub      (sub12),
`endif
        .i_Cin      (cin12),
        .o_Valid    (o_valid12),
        .i_Ready    (rdy12),
        .o_Sum      (o_sum12),
        .o_Cout     (o_cout12),
        .o_Overflow (o_ovf12)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] model16(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic cin,
                                            input logic sub);
        logic [15:0] bb;
        logic        c;
        logic [16:0] r;
        logic        ovf;
        bb  = sub ? ~b : b;
        c   = sub ? 1'b1 : cin;
        r   = {1'b0, a} + {1'b0, bb} + {16'd0, c};
        ovf = (a[15] == bb[15]) && (r[15] != a[15]);
        return {ovf, r};
    endfunction

    function automatic logic [12:0] model12(input logic [11:0] a,
                                            input logic [11:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + {12'd0, cin};
    endfunction

    // Drives one operand and holds it until the DUT accepts it.
    task automatic send16(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
        logic acc;
        acc   = 1'b0;
        a16   = a;
        b16   = b;
        cin16 = cin;
`ifdef PREFIX_ADDER_SUB_EN
        sub16 = sub;
`endif
        v16   = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = o_ready16;
            @(posedge clk);
            #1;
        end
        if (acc) sb16.push_back(model16(a, b, cin, sub));
        else chk("accept16_timeout", 0, 1);
    endtask

    task automatic send12(input logic [11:0] a, input logic [11:0] b,
                          input logic cin);
        logic acc;
        acc   = 1'b0;
        a12   = a;
        b12   = b;
        cin12 = cin;
        v12   = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = o_ready12;
            @(posedge clk);
            #1;
            if (!acc) rdy12 = 1'b1;
        end
        if (acc) sb12.push_back(model12(a, b, cin));
        else chk("accept12_timeout", 0, 1);
    endtask

    // Counts cycles from the accepting edge (=1) to the first o_Valid.
    task automatic latency16(output int cnt);
        cnt = 1;
        while (!o_valid16 && cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sb16.size() != 0 || sb12.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("drain16", sb16.size(), 0);
        chk("drain12", sb12.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid16 && rdy16) begin
            if (sb16.size() == 0) chk("unexpected16", 1, 0);
            else chk("result16", {o_ovf16, o_cout16, o_sum16},
                     sb16.pop_front());
        end
        if (!rst && o_valid12 && rdy12) begin
            if (sb12.size() == 0) chk("unexpected12", 1, 0);
            else chk("result12", {o_cout12, o_sum12}, sb12.pop_front());
        end
    end

    initial begin
        int cnt;
        logic seen;
        clk   = 1'b0;
        rst   = 1'b1;
        v16   = 1'b0;
        a16   = '0;
        b16   = '0;
        cin16 = 1'b0;
        rdy16 = 1'b1;
        v12   = 1'b0;
        a12   = '0;
        b12   = '0;
        cin12 = 1'b0;
        rdy12 = 1'b1;
`ifdef PREFIX_ADDER_SUB_EN
        sub16 = 1'b0;
        sub12 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_valid16", o_valid16, 0);
        chk("rst_ready16", o_ready16, 1);
        chk("rst_out16", {o_ovf16, o_cout16, o_sum16}, 0);
        chk("rst_valid12", o_valid12, 0);
        chk("rst_out12", {o_ovf12, o_cout12, o_sum12}, 0);

        // All-ones plus one: full carry ripple, wraps to zero.
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        v16 = 1'b0;
        latency16(cnt);
        chk("lat_ffff", cnt, 5);
        chk("wrap_ffff", {o_ovf16, o_cout16, o_sum16}, {2'b01, 16'h0000});
        repeat (2) @(posedge clk);
        #1;

        // Largest positive plus one: signed overflow, no carry.
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        v16 = 1'b0;
        latency16(cnt);
        chk("lat_7fff", cnt, 5);
        chk("ovf_7fff", {o_ovf16, o_cout16, o_sum16}, {2'b10, 16'h8000});
        repeat (2) @(posedge clk);
        #1;

`ifdef PREFIX_ADDER_SUB_EN
        send16(16'h0005, 16'h0007, 1'b1, 1'b1);
        v16 = 1'b0;
        latency16(cnt);
        chk("sub_5_7", {o_cout16, o_sum16}, {1'b0, 16'hFFFE});
        repeat (2) @(posedge clk);
        #1;
`endif

        // Back-to-back stream with a 3-cycle stall once results appear.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if (o_valid16) break;
                    @(posedge clk);
                    #1;
                end
                rdy16 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_ready_low", o_ready16, 0);
                    chk("bp_hold", {o_valid16, o_sum16}, {1'b1, 16'd2});
                    @(posedge clk);
                    #1;
                end
                rdy16 = 1'b1;
            end
        join_none
        for (int n = 1; n <= 8; n++) send16(16'(n), 16'(n), 1'b0, 1'b0);
        v16 = 1'b0;
        drain();

        // Random operands with carry-in.
        for (int i = 0; i < 200; i++)
            send16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        v16 = 1'b0;
        drain();

        // Reset with three operands in flight.
        for (int n = 0; n < 3; n++)
            send16(16'(100 + n), 16'h0F0F, 1'b1, 1'b0);
        v16 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb16.delete();
        chk("flush_valid", o_valid16, 0);
        chk("flush_ready", o_ready16, 1);
        chk("flush_out", {o_ovf16, o_cout16, o_sum16}, 0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen = seen | o_valid16;
        end
        chk("flush_quiet", seen, 0);

        // Non-power-of-two width: 0 + 0 + 1.
        send12(12'h000, 12'h000, 1'b1);
        v12 = 1'b0;
        cnt = 1;
        while (!o_valid12 && cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("lat12", cnt, 5);
        chk("w12_cin", {o_cout12, o_sum12}, 13'h001);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10000; i++) begin
            rdy12 = ($urandom_range(0, 3) != 0);
            send12(12'($urandom), 12'($urandom), 1'($urandom));
        end
        v12   = 1'b0;
        rdy12 = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
